// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: one Wishbone B4 pipelined link; dat_m flows master-to-slave, dat_s slave-to-master
interface wb_arbiter2_if #(parameter int ADDR_WIDTH = 4);
  logic cyc, stb, we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0] dat_m, dat_s;
  logic stall, ack, err;
  modport master(output cyc, stb, we, adr, dat_m, input dat_s, stall, ack, err);
  modport slave(input cyc, stb, we, adr, dat_m, output dat_s, stall, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone B4 pipelined arbiter; watchdog enabled by WB_ARBITER2_WATCHDOG_EN
module wb_arbiter2 #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_arbiter2_if.slave     m0,
  wb_arbiter2_if.slave     m1,
  wb_arbiter2_if.master    s
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, nxt;
  logic last_gnt;
  logic [3:0] outst;
  logic g0, g1, sel_cyc, stall_g, ack_fwd, accept, fire, abort;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      outst    <= 4'd0;
    end else begin
      state <= nxt;
      if (g0 | g1) last_gnt <= g1;
      outst <= (!sel_cyc || fire) ? 4'd0 : outst + 4'(accept) - 4'(ack_fwd);
    end
  end
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = (m0.cyc & m1.cyc) ? (last_gnt ? GNT0 : GNT1) : m0.cyc ? GNT0 : m1.cyc ? GNT1 : IDLE;
    else
      nxt = sel_cyc ? state : IDLE;
  end
  always_comb begin
    g0       = state == GNT0;
    g1       = state == GNT1;
    sel_cyc  = (g0 & m0.cyc) | (g1 & m1.cyc);
    s.cyc    = sel_cyc & !abort;
    s.stb    = s.cyc & (g1 ? m1.stb : m0.stb);
    s.we     = g1 ? m1.we : m0.we;
    s.adr    = g1 ? m1.adr : m0.adr;
    s.dat_m  = g1 ? m1.dat_m : m0.dat_m;
    stall_g  = s.stall | (outst == 4'd15) | abort;
    accept   = s.stb & !stall_g;
    // acks with nothing outstanding, or after the owner dropped cyc, are stale
    ack_fwd  = s.ack & (outst != 4'd0) & s.cyc;
    m0.dat_s = s.dat_s;
    m1.dat_s = s.dat_s;
    m0.stall = !g0 | stall_g;
    m1.stall = !g1 | stall_g;
    m0.ack   = g0 & ack_fwd;
    m1.ack   = g1 & ack_fwd;
    m0.err   = g0 & fire;
    m1.err   = g1 & fire;
  end
`ifdef WB_ARBITER2_WATCHDOG_EN
  logic [7:0] wd;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wd    <= 8'd0;
      abort <= 1'b0;
    end else begin
      wd    <= (fire || outst == 4'd0 || s.ack || !sel_cyc) ? 8'd0 : wd + 8'd1;
      abort <= fire | (abort & sel_cyc);
    end
  end
  assign fire = (wd == 8'(WDOG_CYCLES)) & sel_cyc;
`else
  assign fire  = 1'b0;
  assign abort = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed self-checking bench for wb_arbiter2
module tb_wb_arbiter2;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b0;
  int checks = 0;
  int failures = 0;
  int acc, acks;
`ifdef WB_ARBITER2_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  wb_arbiter2_if #(.ADDR_WIDTH(4)) m0();
  wb_arbiter2_if #(.ADDR_WIDTH(4)) m1();
  wb_arbiter2_if #(.ADDR_WIDTH(4)) s();
  wb_arbiter2 #(.ADDR_WIDTH(4), .WDOG_CYCLES(10)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .m0(m0), .m1(m1), .s(s)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask
  initial begin
    m0.cyc = 1; m0.stb = 0; m0.we = 0; m0.adr = 0; m0.dat_m = 0;
    m1.cyc = 1; m1.stb = 0; m1.we = 0; m1.adr = 0; m1.dat_m = 0;
    s.stall = 0; s.ack = 0; s.err = 0; s.dat_s = 32'hDEADBEEF;
    repeat (3) tick();
    check("rst_s_cyc", s.cyc, 0);
    check("rst_s_stb", s.stb, 0);
    check("rst_m0_stall", m0.stall, 1);
    check("rst_m1_stall", m1.stall, 1);
    check("rst_m0_ack", m0.ack, 0);
    check("rst_m0_err", m0.err, 0);
    wb_rst_i = 1; #1;
    check("rel_s_cyc", s.cyc, 0);
    check("rel_m0_stall", m0.stall, 1);
    tick();
    check("gnt0_s_cyc", s.cyc, 1);
    check("gnt0_m0_stall", m0.stall, 0);
    check("gnt0_m1_stall", m1.stall, 1);
    check("gnt0_dat", m0.dat_s, 32'hDEADBEEF);
    m0.stb = 1; m0.we = 1; m0.adr = 3; m0.dat_m = 32'hA5A5A5A5; #1;
    check("wr0_stb", s.stb, 1);
    check("wr0_dat", s.dat_m, 32'hA5A5A5A5);
    check("wr0_adr", s.adr, 3);
    check("wr0_we", s.we, 1);
    tick();
    m0.stb = 0; m0.we = 0; s.ack = 1; #1;
    check("wr0_m0_ack", m0.ack, 1);
    check("wr0_m1_ack", m1.ack, 0);
    tick();
    s.ack = 0; m0.cyc = 0; #1;
    check("drop0_s_cyc", s.cyc, 0);
    tick();
    m0.cyc = 1; #1;
    check("idle_s_cyc", s.cyc, 0);
    check("idle_m0_stall", m0.stall, 1);
    tick();
    check("rr_m1_stall", m1.stall, 0);
    check("rr_m0_stall", m0.stall, 1);
    m1.stb = 1; m1.we = 1; m1.adr = 9; m1.dat_m = 32'h12345678; #1;
    check("wr1_dat", s.dat_m, 32'h12345678);
    check("wr1_adr", s.adr, 9);
    tick();
    m1.stb = 0; s.ack = 1; #1;
    check("wr1_m1_ack", m1.ack, 1);
    check("wr1_m0_ack", m0.ack, 0);
    tick();
    s.ack = 0; m1.cyc = 0;
    tick();
    tick();
    check("regnt0_m0_stall", m0.stall, 0);
    acc = 0; acks = 0;
    for (int k = 0; k < 8; k++) begin
      m0.stb = k < 4; s.ack = k >= 2 && k < 6; #1;
      if (m0.stb && !m0.stall) acc++;
      if (m0.ack) acks++;
      check("burst_s_cyc", s.cyc, 1);
      tick();
    end
    m0.stb = 0; s.ack = 0;
    check("burst_acc", acc, 4);
    check("burst_acks", acks, 4);
    s.ack = 1; #1;
    check("stray_ack", m0.ack, 0);
    tick();
    s.ack = 0;
`ifndef WB_ARBITER2_WATCHDOG_EN
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      m0.stb = 1; #1;
      check("sat_stall", m0.stall, i >= 15);
      if (!m0.stall) acc++;
      tick();
    end
    m0.stb = 0;
    check("sat_acc", acc, 15);
`endif
    m0.cyc = 0; m1.cyc = 1;
    tick();
    tick();
    check("ab_m1_gnt", m1.stall, 0);
    for (int i = 0; i < 3; i++) begin
      m1.stb = 1;
      tick();
    end
    m1.stb = 0; m1.cyc = 0; m0.cyc = 1; s.ack = 1; #1;
    check("ab1_m1_ack", m1.ack, 0);
    check("ab1_m0_ack", m0.ack, 0);
    tick();
    check("ab2_m1_ack", m1.ack, 0);
    check("ab2_m0_ack", m0.ack, 0);
    tick();
    check("ab3_m0_ack", m0.ack, 0);
    check("ab3_m0_gnt", m0.stall, 0);
    s.ack = 0;
    m0.stb = 1; #1;
    tick();
    m0.stb = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("wd_m0_err", m0.err, k == 10 && WD_EN);
      if (k == 10) check("wd_m1_err", m1.err, 0);
      if (k == 11) check("wd_s_cyc", s.cyc, !WD_EN);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
